// File: rtl/rgb_pwm_pkg.sv
// ------------------------------------------------------------------
// rgb_pwm_pkg : shared types and constants for the RGB PWM generator
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

package rgb_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] PCNT_MAX = 8'd254;

  // Width of a counter spanning 0..div-1, never narrower than one bit.
  function automatic int presc_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_channel.sv
// ------------------------------------------------------------------
// pwm_channel : stability filter, period-boundary shadow and comparator
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] time_in,
  input  logic              load_shadow,
  input  logic              run,
  input  logic [DUTY_W-1:0] pcnt,
  output logic              pwm_out
);

  logic [DUTY_W-1:0] stage;
  logic [DUTY_W-1:0] stable;
  logic [DUTY_W-1:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage   <= '0;
      stable  <= '0;
      shadow  <= '0;
      pwm_out <= ACTIVE_LOW;
    end else begin
      stage <= time_in;
      // Accept a value only once it has been seen on two consecutive edges.
      if (stage == time_in) begin
        stable <= time_in;
      end
      if (load_shadow) begin
        shadow <= stable;
      end
      pwm_out <= ACTIVE_LOW ^ (run && (pcnt < shadow));
    end
  end

endmodule

`default_nettype wire

// File: rtl/rgb_pwm_generator.sv
// ------------------------------------------------------------------
// rgb_pwm_generator : three-channel glitch-free PWM for the RGB LED pins
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module rgb_pwm_generator
  import rgb_pwm_pkg::*;
#(
  parameter int CLK_DIV    = 390,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DUTY_W-1:0] R_time_in,
  input  logic [DUTY_W-1:0] G_time_in,
  input  logic [DUTY_W-1:0] B_time_in,
  output logic              R_out,
  output logic              G_out,
  output logic              B_out,
  output logic              period_start
);

  localparam int PW = presc_width(CLK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  state_t            state;
  logic [PW-1:0]     presc;
  logic [DUTY_W-1:0] pcnt;
  logic              run;
  logic              tick;
  logic              wrap;
  logic              load_shadow;
  logic [DUTY_W-1:0] time_in [3];
  logic [2:0]        ch_out;

  assign run         = (state == RUN);
  assign tick        = run && (presc == PRESC_LAST);
  assign wrap        = tick && (pcnt == PCNT_MAX);
  assign load_shadow = (state == LOAD) || wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      presc        <= '0;
      pcnt         <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= run && (pcnt == '0) && (presc == '0);
      case (state)
        IDLE: begin
          presc <= '0;
          pcnt  <= '0;
          if (en) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          presc <= '0;
          pcnt  <= '0;
          state <= RUN;
        end
        RUN: begin
          // Dropping en truncates the current period rather than finishing it.
          if (!en) begin
            state <= IDLE;
            presc <= '0;
            pcnt  <= '0;
          end else if (tick) begin
            presc <= '0;
            pcnt  <= wrap ? '0 : pcnt + DUTY_W'(1);
          end else begin
            presc <= presc + PW'(1);
          end
        end
        default: begin
          state <= IDLE;
          presc <= '0;
          pcnt  <= '0;
        end
      endcase
    end
  end

  assign time_in[0] = R_time_in;
  assign time_in[1] = G_time_in;
  assign time_in[2] = B_time_in;

  for (genvar i = 0; i < 3; i++) begin : g_chan
    pwm_channel #(
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .time_in     (time_in[i]),
      .load_shadow (load_shadow),
      .run         (run),
      .pcnt        (pcnt),
      .pwm_out     (ch_out[i])
    );
  end

  assign R_out = ch_out[0];
  assign G_out = ch_out[1];
  assign B_out = ch_out[2];

endmodule

`default_nettype wire

// File: tb/tb_rgb_pwm_generator.sv
// ------------------------------------------------------------------
// tb_rgb_pwm_generator : directed vector bench for rgb_pwm_generator
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_rgb_pwm_generator;

  localparam int CLK_DIV = 4;
  localparam int PER     = 255 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] r_in, g_in, b_in;
  logic       r_out, g_out, b_out, ps;
  logic       rn_out, gn_out, bn_out, psn;

  always #5 clk = ~clk;

  rgb_pwm_generator #(.CLK_DIV(CLK_DIV), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .R_time_in(r_in), .G_time_in(g_in), .B_time_in(b_in),
    .R_out(r_out), .G_out(g_out), .B_out(b_out), .period_start(ps)
  );

  rgb_pwm_generator #(.CLK_DIV(CLK_DIV), .ACTIVE_LOW(1'b1)) dut_n (
    .clk(clk), .rst_n(rst_n), .en(en),
    .R_time_in(r_in), .G_time_in(g_in), .B_time_in(b_in),
    .R_out(rn_out), .G_out(gn_out), .B_out(bn_out), .period_start(psn)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] r, g, b;
    int         er, eg, eb;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ps(input string name);
    int n = 0;
    while (ps !== 1'b1 && n < PER + 80) begin
      @(negedge clk);
      n++;
    end
    if (ps !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: period_start not seen within %0d clks", name, n);
    end
  endtask

  // Starts on a sample where period_start is high; ends on the next one.
  task automatic measure(input string tag, input int er, input int eg, input int eb,
                         input int chg_at, input logic [7:0] chg_val,
                         input int rst_at, input logic [7:0] rst_val);
    int rh = 0, gh = 0, bh = 0, rl = 0, gl = 0, bl = 0, extra = 0;
    for (int i = 0; i < PER; i++) begin
      if (i == chg_at) r_in = chg_val;
      if (i == rst_at) r_in = rst_val;
      rh += int'(r_out);
      gh += int'(g_out);
      bh += int'(b_out);
      rl += int'(!rn_out);
      gl += int'(!gn_out);
      bl += int'(!bn_out);
      if (i != 0 && ps) extra++;
      @(negedge clk);
    end
    check({tag, "_r_high"}, rh, er);
    check({tag, "_g_high"}, gh, eg);
    check({tag, "_b_high"}, bh, eb);
    check({tag, "_rn_low"}, rl, er);
    check({tag, "_gn_low"}, gl, eg);
    check({tag, "_bn_low"}, bl, eb);
    check({tag, "_ps_period"}, int'(ps), 1);
    check({tag, "_ps_extra"}, extra, 0);
  endtask

  // Raise en (or release reset with en held) at a negedge; expect LOAD, RUN,
  // then period_start and the first output level on the third edge.
  task automatic start_check(input string tag, input bit via_reset,
                             input int er, input int eg, input int eb);
    if (via_reset) rst_n = 1'b1;
    else           en    = 1'b1;
    @(negedge clk);
    check({tag, "_ps_edge1"}, int'(ps), 0);
    @(negedge clk);
    check({tag, "_ps_edge2"}, int'(ps), 0);
    check({tag, "_r_edge2"}, int'(r_out), 0);
    @(negedge clk);
    check({tag, "_ps_edge3"}, int'(ps), 1);
    check({tag, "_r_edge3"}, int'(r_out), er);
    check({tag, "_g_edge3"}, int'(g_out), eg);
    check({tag, "_b_edge3"}, int'(b_out), eb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int psc;
    vecs[0] = '{r: 8'h7F, g: 8'h1F, b: 8'hFF, er: 508,  eg: 124, eb: 1020};
    vecs[1] = '{r: 8'h00, g: 8'h80, b: 8'h01, er: 0,    eg: 512, eb: 4};
    vecs[2] = '{r: 8'hFE, g: 8'h00, b: 8'h7F, er: 1016, eg: 0,   eb: 508};
    vecs[3] = '{r: 8'h10, g: 8'h20, b: 8'h40, er: 64,   eg: 128, eb: 256};

    rst_n = 1'b0;
    en    = 1'b0;
    r_in  = 8'h00;
    g_in  = 8'h00;
    b_in  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_r", int'(r_out), 0);
    check("rst_g", int'(g_out), 0);
    check("rst_b", int'(b_out), 0);
    check("rst_ps", int'(ps), 0);
    check("rst_rn", int'(rn_out), 1);
    check("rst_gn", int'(gn_out), 1);
    check("rst_bn", int'(bn_out), 1);

    rst_n = 1'b1;
    r_in  = 8'h7F;
    g_in  = 8'h1F;
    b_in  = 8'hFF;
    repeat (4) @(negedge clk);
    check("idle_ps", int'(ps), 0);
    check("idle_b", int'(b_out), 0);
    start_check("en_rise", 1'b0, 1, 1, 1);

    for (int v = 0; v < 4; v++) begin
      r_in = vecs[v].r;
      g_in = vecs[v].g;
      b_in = vecs[v].b;
      @(negedge clk);
      wait_ps($sformatf("vec%0d_sync", v));
      measure($sformatf("vec%0d", v), vecs[v].er, vecs[v].eg, vecs[v].eb,
              -1, 8'h00, -1, 8'h00);
    end

    // Duty drop at pcnt = 50: current period completes, next one is dark.
    r_in = 8'h7F;
    g_in = 8'h1F;
    b_in = 8'hFF;
    @(negedge clk);
    wait_ps("midchg_sync");
    measure("midchg", 508, 124, 1020, 200, 8'h00, -1, 8'h00);
    measure("midchg_next", 0, 124, 1020, -1, 8'h00, -1, 8'h00);

    // One-clock AA glitch timed so an unfiltered value would hit the boundary.
    r_in = 8'h7F;
    @(negedge clk);
    wait_ps("glitch_sync");
    measure("glitch_pre", 508, 124, 1020, PER - 3, 8'hAA, PER - 2, 8'h7F);
    measure("glitch_post", 508, 124, 1020, -1, 8'h00, -1, 8'h00);

    r_in = 8'h00;
    @(negedge clk);
    wait_ps("rzero_sync");
    for (int p = 0; p < 3; p++) begin
      measure($sformatf("rzero_p%0d", p), 0, 124, 1020, -1, 8'h00, -1, 8'h00);
    end

    // en fall at pcnt = 100, then re-enable.
    r_in = 8'h7F;
    @(negedge clk);
    wait_ps("enfall_sync");
    repeat (400) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("enfall_r_edge1", int'(r_out), 1);
    check("enfall_b_edge1", int'(b_out), 1);
    @(negedge clk);
    check("enfall_r_edge2", int'(r_out), 0);
    check("enfall_b_edge2", int'(b_out), 0);
    check("enfall_bn_edge2", int'(bn_out), 1);
    psc = 0;
    repeat (20) begin
      @(negedge clk);
      psc += int'(ps);
    end
    check("enfall_no_ps", psc, 0);
    start_check("en_rerise", 1'b0, 1, 1, 1);

    // Asynchronous reset mid-period; the filter restarts from zero, so the
    // first period after release is dark.
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_r", int'(r_out), 0);
    check("arst_b", int'(b_out), 0);
    check("arst_rn", int'(rn_out), 1);
    check("arst_ps", int'(ps), 0);
    @(negedge clk);
    start_check("rst_restart", 1'b1, 0, 0, 0);
    measure("post_rst_p0", 0, 0, 0, -1, 8'h00, -1, 8'h00);
    measure("post_rst_p1", 508, 124, 1020, -1, 8'h00, -1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rgb_pwm_generator.md
# rgb_pwm_generator

Three-channel PWM generator that drives the RGB LED pins from the 8-bit R/G/B on-time values produced by the switch-to-colour decoder. It filters the decoder outputs for stability and double-buffers them so duty changes take effect only at period boundaries. It then produces glitch-free PWM waveforms from a prescaled 8-bit period counter. It sits directly downstream of the decoder and directly upstream of the board LED pins.

## Interface
- CLK_DIV, 390: system clocks per PWM tick, ≥ 2. 100 MHz / 390 / 255 gives ≈ 1 kHz PWM.
- ACTIVE_LOW, 0: when 1, all three LED outputs are inverted.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable. Synchronous to clk.
- R_time_in  in  8  red on-time. 0x00 means always off; 0xFF means always on.
- G_time_in  in  8  green on-time, same encoding as red.
- B_time_in  in  8  blue on-time, same encoding as red.
- R_out  out  1  red PWM output, registered.
- G_out  out  1  green PWM output, registered.
- B_out  out  1  blue PWM output, registered.
- period_start  out  1  one-clk pulse on the first output cycle of each PWM period.

## Operation
- Stability filter, per channel:
  - stage register samples the input every clk.
  - stable register loads the input only when stage equals the current input (input unchanged across 2 consecutive edges).
  - Multi-bit glitches from switch bounce are rejected.
- Prescaler presc counts 0..CLK_DIV-1. tick = (presc == CLK_DIV-1).
- Period counter pcnt, 8 bits, counts 0..254 and advances on tick. Period = 255 ticks.
- Compare: channel active = (pcnt < shadow). Active ticks per period = duty, exactly:
  - 0x00 gives 0 active ticks.
  - 0xFF gives 255 of 255 active ticks (always on).
- FSM states: IDLE, LOAD, RUN.
  - IDLE: presc = pcnt = 0; outputs at inactive level. Go to LOAD when en = 1.
  - LOAD (1 cycle): shadow ← stable for all channels. presc = pcnt = 0. Go to RUN.
  - RUN: counters advance. When tick && pcnt == 254: pcnt ← 0 and shadow ← stable (new duty applies from next period). en = 0 → IDLE on next edge.
- Output register: X_out ← ACTIVE_LOW ^ (state == RUN && pcnt < X_shadow).
- period_start ← (state == RUN && pcnt == 0 && presc == 0).
- Shadow never changes mid-period, so there are no runt pulses.

## Timing
- Reset values:
  - FSM = IDLE.
  - presc, pcnt, stage, stable, shadow = 0.
  - R_out/G_out/B_out = ACTIVE_LOW.
  - period_start = 0.
- en rise at edge N: LOAD at N+1, RUN at N+2, first period_start and first active output level at edge N+3.
- Output latency: 1 clk behind the pcnt/presc state.
- Input-to-shadow latency: 2 clks through the filter, plus a wait until the next period boundary (worst case 255·CLK_DIV clks).
- en fall in RUN: outputs inactive and counters zero 2 edges later. A partial period is truncated, not completed.
- rst_n asserted mid-period: all state returns to reset values immediately (asynchronous). On release, the block restarts from IDLE.
- Input change coincident with the boundary update: shadow takes the old stable value. The new value applies one period later.

## Structure
- Package rgb_pwm_pkg holds:
  - state enum {IDLE, LOAD, RUN}.
  - DUTY_W = 8.
  - PCNT_MAX = 254.
  - Prescaler width function $clog2(CLK_DIV).
- Sub-module pwm_channel, instantiated 3×, contains:
  - stage, stable and shadow registers.
  - Comparator and registered output.
  - Inputs: load_shadow and run.
- The top level holds the FSM, prescaler, pcnt and period_start.

## Test plan
- CLK_DIV = 4, in = 7F/1F/FF, en = 1 → per 1020-clk period, R high 508 clks, G high 124 clks, B high 1020 clks. period_start every 1020 clks.
- R_time_in = 00 → R_out never high across 3 periods. With ACTIVE_LOW = 1, R_out is constantly 1.
- Change R 7F → 00 at pcnt = 50 → current period keeps its 508-clk high pulse. The next period's R_out stays low. No runt pulse.
- Single-cycle glitch R_time_in = AA between 7F values → shadow stays 7F and the waveform is unchanged.
- en fall at pcnt = 100 → outputs inactive within 2 clks. en rise → period_start and outputs 3 edges later.
- rst_n pulse mid-period → outputs = ACTIVE_LOW immediately. After release with en = 1, the restart timing matches the en-rise case.
